// File: rtl/neuro_host_pkg.sv
// Shared definitions for the neuromorphic host master: responder register map and sequencer states.
package neuro_host_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned RES_BYTES = 8;
    localparam int unsigned RES_W     = RES_BYTES * DATA_W;

    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 8'h01;
    localparam logic [ADDR_W-1:0] ADDR_THRESH   = 8'h02;
    localparam logic [ADDR_W-1:0] ADDR_LEAK     = 8'h03;
    localparam logic [ADDR_W-1:0] ADDR_LRATE    = 8'h04;
    localparam logic [ADDR_W-1:0] ADDR_OUT_BASE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        WR_CFG,
        POLL_REQ,
        POLL_WAIT,
        RD_REQ,
        RD_WAIT,
        FINISH
    } state_e;

    // Configuration write slot -> register address; slot 3 (control) is always written last.
    function automatic logic [ADDR_W-1:0] cfg_addr(input logic [IDX_W-1:0] slot);
        logic [ADDR_W-1:0] a;
        case (slot)
            3'd0:    a = ADDR_THRESH;
            3'd1:    a = ADDR_LEAK;
            3'd2:    a = ADDR_LRATE;
            default: a = ADDR_CTRL;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/neuro_host_master.sv
// Host-side sequencer: configures the neuromorphic core, polls status, reads 8 output bytes, with abort timeout.
// Define NEURO_HOST_CFG_EN to write threshold/leak/lrate before control; otherwise only control is written.
module neuro_host_master
    import neuro_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_threshold,
    input  logic [DATA_W-1:0] cfg_leak,
    input  logic [DATA_W-1:0] cfg_lrate,
    input  logic [DATA_W-1:0] cfg_control,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    output logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_write_enable,
    output logic [DATA_W-1:0] cpu_write_data,
    output logic              cpu_read_enable,
    input  logic [DATA_W-1:0] cpu_read_data,
    input  logic              cpu_ready
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef NEURO_HOST_CFG_EN
    localparam logic [IDX_W-1:0] FIRST_WR = 3'd0;
`else
    localparam logic [IDX_W-1:0] FIRST_WR = 3'd3;
`endif
    localparam logic [IDX_W-1:0] LAST_WR  = 3'd3;
    localparam logic [IDX_W-1:0] LAST_OUT = 3'd7;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               rvalid_q, rvalid_d;
    logic               terr_q, terr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               we_q, we_d;
    logic               re_q, re_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    // Next state; bus strobes are decoded from the next state so they register alongside it.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rvalid_d = rvalid_q;
        terr_d   = terr_q;
        done_d   = 1'b0;
        we_d     = 1'b0;
        re_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WR_CFG;
                    idx_d    = FIRST_WR;
                    cnt_d    = '0;
                    rvalid_d = 1'b0;
                    terr_d   = 1'b0;
                end
            end
            FINISH: state_d = IDLE;
            default: begin
                if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    // Abort wins over any response arriving in the same cycle.
                    state_d = IDLE;
                    terr_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    case (state_q)
                        WR_CFG: begin
                            if (idx_q == LAST_WR) state_d = POLL_REQ;
                            else                  idx_d   = idx_q + IDX_W'(1);
                        end
                        POLL_REQ: state_d = POLL_WAIT;
                        POLL_WAIT: begin
                            if (cpu_ready) begin
                                if (cpu_read_data[0]) begin
                                    state_d = RD_REQ;
                                    idx_d   = '0;
                                end else begin
                                    state_d = POLL_REQ;
                                end
                            end
                        end
                        RD_REQ: state_d = RD_WAIT;
                        RD_WAIT: begin
                            if (cpu_ready) begin
                                result_d[{idx_q, 3'b000} +: DATA_W] = cpu_read_data;
                                if (idx_q == LAST_OUT) begin
                                    state_d  = FINISH;
                                    rvalid_d = 1'b1;
                                    done_d   = 1'b1;
                                end else begin
                                    state_d = RD_REQ;
                                    idx_d   = idx_q + IDX_W'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        case (state_d)
            WR_CFG: begin
                we_d   = 1'b1;
                addr_d = cfg_addr(idx_d);
                case (idx_d)
                    3'd0:    wdata_d = cfg_threshold;
                    3'd1:    wdata_d = cfg_leak;
                    3'd2:    wdata_d = cfg_lrate;
                    default: wdata_d = cfg_control;
                endcase
            end
            POLL_REQ: begin
                re_d   = 1'b1;
                addr_d = ADDR_STATUS;
            end
            RD_REQ: begin
                re_d   = 1'b1;
                addr_d = ADDR_OUT_BASE + ADDR_W'(idx_d);
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            terr_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            terr_q   <= terr_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            re_q     <= re_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign timeout_err      = terr_q;
    assign result           = result_q;
    assign result_valid     = rvalid_q;
    assign cpu_addr         = addr_q;
    assign cpu_write_enable = we_q;
    assign cpu_write_data   = wdata_q;
    assign cpu_read_enable  = re_q;

endmodule

// File: doc/neuro_host_master.md
NEURO_HOST_MASTER -- requirements
Module: neuro_host_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: busy-cycle limit before an inference is aborted.
REQ-002 SHALL have port clk  input  1  system clock. One clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request one inference; sampled only in IDLE.
REQ-005 SHALL have ports cfg_threshold, cfg_leak, cfg_lrate, cfg_control  input  8 each  values written to the responder.
REQ-006 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-007 SHALL have port done  output  1  one-cycle pulse at the end of every run, successful or aborted.
REQ-008 SHALL have port timeout_err  output  1  last run aborted.
REQ-009 SHALL have port result  output  64  output bytes 0..7; byte i is at [8i+7:8i].
REQ-010 SHALL have port result_valid  output  1  result holds a complete run.
REQ-011 SHALL have ports cpu_addr (output 8), cpu_write_enable (output 1), cpu_write_data (output 8), cpu_read_enable (output 1): initiator side of the neuromorphic memory-mapped bus.
REQ-012 SHALL have ports cpu_read_data (input 8) and cpu_ready (input 1): read return from the responder.

Function
REQ-013 Bus protocol:
- Write: a single-cycle cpu_write_enable strobe with addr and data; it completes immediately, with no ready.
- Read: a single-cycle cpu_read_enable strobe; data is valid while cpu_ready=1 on a later cycle.
REQ-014 The two strobes SHALL never both be high; cpu_addr and cpu_write_data SHALL be 0 when no strobe is active.
REQ-015 States SHALL be IDLE, WR_CFG, POLL_REQ, POLL_WAIT, RD_REQ, RD_WAIT, FINISH.
REQ-016 start=1 in IDLE at edge T SHALL:
- clear result_valid and timeout_err;
- enter WR_CFG;
- issue these writes on cycles T+1..T+4: 0x02=cfg_threshold, 0x03=cfg_leak, 0x04=cfg_lrate, 0x00=cfg_control.
REQ-017 After the last write, the block SHALL enter POLL_REQ: a one-cycle read of 0x01, then POLL_WAIT.
REQ-018 In POLL_WAIT with cpu_ready=1, the block SHALL go to RD_REQ if cpu_read_data[0]=1, else back to POLL_REQ.
REQ-019 RD_REQ SHALL read address 0x20+idx, idx = 0..7, then enter RD_WAIT.
REQ-020 In RD_WAIT with cpu_ready=1, the block SHALL store cpu_read_data into result byte idx.
- idx<7: increment idx and go to RD_REQ.
- idx=7: go to FINISH.
REQ-021 FINISH SHALL last one cycle: done=1, result_valid=1, then IDLE.
REQ-022 cpu_ready outside POLL_WAIT/RD_WAIT SHALL be ignored.
REQ-023 start while busy SHALL be ignored.
REQ-024 Timeout counter (width ceil(log2(TIMEOUT_CYCLES+1))):
- cleared on an accepted start; increments each busy cycle.
- On reaching TIMEOUT_CYCLES in any state, the next cycle SHALL drop strobes, set timeout_err=1, pulse done, keep result_valid=0, and return to IDLE.
REQ-025 Timeout SHALL take priority over a same-cycle cpu_ready.
REQ-026 result, result_valid and timeout_err SHALL hold until the next accepted start.

Reset
REQ-027 On rst=1 at a clock edge, all outputs SHALL be 0, the state IDLE, and idx and the counter 0.
REQ-028 rst SHALL abort a run in progress within that same edge, with no done pulse.

Configuration
REQ-029 With NEURO_HOST_CFG_EN defined, WR_CFG SHALL issue the four writes of REQ-016.
REQ-030 Without NEURO_HOST_CFG_EN:
- WR_CFG SHALL issue only 0x00=cfg_control, on T+1, with polling starting at T+2.
- cfg_threshold, cfg_leak and cfg_lrate SHALL remain as ports and be ignored.

Structure
REQ-031 Shared package neuro_host_pkg SHALL hold the register addresses (CTRL 0x00, STATUS 0x01, THRESH 0x02, LEAK 0x03, LRATE 0x04, OUT_BASE 0x20) and the state enum.
REQ-032 The block SHALL be a single module with no sub-module.

Verification (responder model returns cpu_ready one cycle after a read)
REQ-033 cfg 200/1/10/0x01, start at T, status bit0=1 on the first poll -> writes 0x02=C8, 0x03=01, 0x04=0A, 0x00=01 on T+1..T+4, read 0x01 on T+5, then eight output reads; done=1 and result_valid=1 in FINISH.
REQ-034 Status returns bit0=0 three times, then 1, outputs FF,00,FF,00,00,00,00,FF -> exactly 4 status reads; result=64'hFF00_0000_00FF_00FF.
REQ-035 TIMEOUT_CYCLES=20, status always 0 -> done pulse with timeout_err=1 and result_valid=0; no strobe after the abort.
REQ-036 start re-asserted during polling, plus a spurious cpu_ready in IDLE -> no restart and no capture.
REQ-037 rst during RD_WAIT at idx=3 -> all outputs 0 on the next cycle and no done pulse.
REQ-038 Build without NEURO_HOST_CFG_EN -> a single write 0x00 on T+1, then poll on T+2.
